// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with 16x oversampling, 3-sample majority vote and per-frame baud select.
// Data_Byte holds the last well-framed byte; Rx_Done/Frame_err are single-cycle pulses.
module uart_rx_byte #(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Rs232_Rx,
  input  logic [2:0] Baud_set,
  output logic [7:0] Data_Byte,
  output logic       Rx_Done,
  output logic       Frame_err,
  output logic       UART_state
);

  // Rounded clocks per 16x tick for each supported rate.
  localparam int unsigned N9600   = (CLK_FREQ + 8 * 9600) / (16 * 9600);
  localparam int unsigned N19200  = (CLK_FREQ + 8 * 19200) / (16 * 19200);
  localparam int unsigned N38400  = (CLK_FREQ + 8 * 38400) / (16 * 38400);
  localparam int unsigned N57600  = (CLK_FREQ + 8 * 57600) / (16 * 57600);
  localparam int unsigned N115200 = (CLK_FREQ + 8 * 115200) / (16 * 115200);
  localparam int unsigned DivW    = $clog2(N9600 + 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic            sync1_q, sync2_q, hist_q;
  logic [DivW-1:0] div_q, div_d, div_max;
  logic [3:0]      tick_q, tick_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [1:0]      samp_q, samp_d;
  logic [2:0]      baud_q, baud_d;
  logic [7:0]      data_q, data_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
  logic            busy_q, busy_d;
  logic            rx_s, fall, tick, maj;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= Rs232_Rx;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign rx_s = sync2_q;
  assign fall = hist_q & ~sync2_q;

  always_comb begin
    case (baud_q)
      3'd1:    div_max = DivW'(N19200 - 1);
      3'd2:    div_max = DivW'(N38400 - 1);
      3'd3:    div_max = DivW'(N57600 - 1);
      3'd4:    div_max = DivW'(N115200 - 1);
      default: div_max = DivW'(N9600 - 1);
    endcase
  end

  assign tick = (state_q != StIdle) && (div_q == div_max);
  // Samples from ticks 7 and 8 plus the live value at tick 9.
  assign maj  = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    samp_d  = samp_q;
    baud_d  = baud_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    busy_d  = busy_q;

    if (state_q != StIdle) begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) begin
        tick_d = tick_q + 4'd1;
        if (tick_q == 4'd7) samp_d[0] = rx_s;
        if (tick_q == 4'd8) samp_d[1] = rx_s;
      end
    end

    case (state_q)
      StIdle: begin
        if (fall) begin
          div_d   = '0;
          tick_d  = '0;
          baud_d  = Baud_set;
          busy_d  = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        if (tick && tick_q == 4'd9 && maj) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end else if (tick && tick_q == 4'd15) begin
          bit_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (tick && tick_q == 4'd9) shift_d = {maj, shift_q[7:1]};
        if (tick && tick_q == 4'd15) begin
          if (bit_q == 3'd7) state_d = StStop;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      StStop: begin
        // Leave at tick 9 so a start bit immediately after the stop bit is caught.
        if (tick && tick_q == 4'd9) begin
          if (maj) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= StIdle;
      div_q   <= '0;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      samp_q  <= '0;
      baud_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      samp_q  <= samp_d;
      baud_q  <= baud_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign Data_Byte  = data_q;
  assign Rx_Done    = done_q;
  assign Frame_err  = ferr_q;
  assign UART_state = busy_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte, run at CLK_FREQ = 25 MHz so the 9600-baud pair stays short.
// Hand-derived tick periods at 25 MHz: 9600 -> 163, 38400 -> 41, 115200 -> 14 clocks.
module tb_uart_rx_byte;

  localparam int unsigned ClkFreq = 25_000_000;
  localparam int unsigned NB0 = 163;
  localparam int unsigned NB2 = 41;
  localparam int unsigned NB4 = 14;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Rs232_Rx;
  logic [2:0] Baud_set;
  logic [7:0] Data_Byte;
  logic       Rx_Done, Frame_err, UART_state;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Event monitor, sampled on the falling edge.
  int unsigned cyc = 0, done_cnt = 0, ferr_cnt = 0, both_cnt = 0;
  logic [7:0]  done_bytes[$];
  int unsigned done_cycs[$];

  uart_rx_byte #(.CLK_FREQ(ClkFreq)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Rs232_Rx  (Rs232_Rx),
    .Baud_set  (Baud_set),
    .Data_Byte (Data_Byte),
    .Rx_Done   (Rx_Done),
    .Frame_err (Frame_err),
    .UART_state(UART_state)
  );

  always #10 Clk = ~Clk;

  always @(negedge Clk) begin
    cyc++;
    if (Rx_Done) begin
      done_cnt++;
      done_bytes.push_back(Data_Byte);
      done_cycs.push_back(cyc);
    end
    if (Frame_err) ferr_cnt++;
    if (Rx_Done && Frame_err) both_cnt++;
  end

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Drives start, 8 data bits LSB first and the stop bit; goff != 0 inverts one clock per bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int unsigned bitc,
                            input int unsigned goff);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      Rs232_Rx = bits[i];
      if (goff != 0) begin
        wait_clk(goff);
        Rs232_Rx = ~bits[i];
        wait_clk(1);
        Rs232_Rx = bits[i];
        wait_clk(bitc - goff - 1);
      end else begin
        wait_clk(bitc);
      end
    end
  endtask

  // Counts falling edges until Rx_Done or Frame_err; tracks UART_state staying high meanwhile.
  task automatic wait_pulse(input int unsigned budget, output int unsigned cycles,
                            output bit seen, output bit busy_ok);
    seen = 1'b0;
    busy_ok = 1'b1;
    cycles = 0;
    for (int unsigned c = 1; c <= budget; c++) begin
      @(negedge Clk);
      if (c >= 4 && !UART_state && !Rx_Done && !Frame_err) busy_ok = 1'b0;
      if (Rx_Done || Frame_err) begin
        seen = 1'b1;
        cycles = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit started;
    Rst = 1'b1;
    Rs232_Rx = 1'b0;
    Baud_set = 3'd4;
    wait_clk(5);
    n_vec++;
    if (Data_Byte !== 8'h00) begin
      n_err++; $display("FAIL reset_data: got %h, expected 00", Data_Byte);
    end
    n_vec++;
    if ({Rx_Done, Frame_err, UART_state} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: got %b, expected 000", {Rx_Done, Frame_err, UART_state});
    end
    Rst = 1'b0;
    started = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (UART_state) started = 1'b1;
    end
    n_vec++;
    if (started !== 1'b0) begin
      n_err++; $display("FAIL reset_low_line: got start %b, expected 0", started);
    end
    wait_clk(1);
    Rs232_Rx = 1'b1;
    wait_clk(20);
    n_vec++;
    if (UART_state !== 1'b0) begin
      n_err++; $display("FAIL reset_rise: got UART_state %b, expected 0", UART_state);
    end
  endtask

  task automatic test_basic();
    int unsigned cycles, d0, f0, lat;
    bit seen, busy_ok;
    Baud_set = 3'd4;
    lat = 2 + 154 * NB4;
    d0 = done_cnt;
    f0 = ferr_cnt;
    fork
      send_frame(8'hA5, 1'b1, 16 * NB4, 0);
      wait_pulse(lat + 4 * NB4, cycles, seen, busy_ok);
    join
    wait_clk(5);
    n_vec++;
    if (!seen || cycles < lat - NB4 || cycles > lat + NB4) begin
      n_err++; $display("FAIL basic_latency: got %0d (seen %b), expected %0d +/- %0d",
                        cycles, seen, lat, NB4);
    end
    n_vec++;
    if (Data_Byte !== 8'hA5) begin
      n_err++; $display("FAIL basic_data: got %h, expected a5", Data_Byte);
    end
    n_vec++;
    if (busy_ok !== 1'b1) begin
      n_err++; $display("FAIL basic_busy: UART_state dropped mid-frame, expected high");
    end
    n_vec++;
    if (done_cnt - d0 !== 1 || ferr_cnt - f0 !== 0) begin
      n_err++; $display("FAIL basic_pulses: got done %0d ferr %0d, expected 1 0",
                        done_cnt - d0, ferr_cnt - f0);
    end
    n_vec++;
    if (UART_state !== 1'b0) begin
      n_err++; $display("FAIL basic_idle: got UART_state %b, expected 0", UART_state);
    end
  endtask

  task automatic test_back_to_back();
    int idx;
    idx = done_bytes.size();
    Baud_set = 3'd0;
    fork
      begin
        send_frame(8'h00, 1'b1, 16 * NB0, 0);
        send_frame(8'hFF, 1'b1, 16 * NB0, 0);
      end
      begin
        // Code 7 decodes to 9600 and is only picked up by the second frame.
        wait_clk(1000);
        Baud_set = 3'd7;
      end
    join
    wait_clk(10);
    n_vec++;
    if (done_bytes.size() - idx !== 2) begin
      n_err++; $display("FAIL b2b_count: got %0d Rx_Done, expected 2", done_bytes.size() - idx);
    end
    if (done_bytes.size() >= idx + 2) begin
      n_vec++;
      if (done_bytes[idx] !== 8'h00) begin
        n_err++; $display("FAIL b2b_first: got %h, expected 00", done_bytes[idx]);
      end
      n_vec++;
      if (done_bytes[idx+1] !== 8'hFF) begin
        n_err++; $display("FAIL b2b_second: got %h, expected ff", done_bytes[idx+1]);
      end
      n_vec++;
      if (done_cycs[idx+1] - done_cycs[idx] < 160 * NB0 - NB0 ||
          done_cycs[idx+1] - done_cycs[idx] > 160 * NB0 + NB0) begin
        n_err++; $display("FAIL b2b_gap: got %0d, expected %0d", done_cycs[idx+1] - done_cycs[idx],
                          160 * NB0);
      end
    end
    Baud_set = 3'd4;
  endtask

  task automatic test_false_start();
    int unsigned d0, f0, fall_c;
    bit rose;
    Baud_set = 3'd4;
    d0 = done_cnt;
    f0 = ferr_cnt;
    rose = 1'b0;
    fall_c = 0;
    fork
      begin
        Rs232_Rx = 1'b0;
        wait_clk(100);
        Rs232_Rx = 1'b1;
      end
      for (int unsigned c = 1; c <= 600; c++) begin
        @(negedge Clk);
        if (UART_state) rose = 1'b1;
        else if (rose && fall_c == 0) fall_c = c;
      end
    join
    n_vec++;
    if (rose !== 1'b1 || fall_c == 0 || fall_c > 16 * NB4 + 3) begin
      n_err++; $display("FAIL false_start_state: got rose %b fall %0d, expected 1 and <= %0d",
                        rose, fall_c, 16 * NB4 + 3);
    end
    n_vec++;
    if (done_cnt - d0 !== 0 || ferr_cnt - f0 !== 0) begin
      n_err++; $display("FAIL false_start_pulses: got done %0d ferr %0d, expected 0 0",
                        done_cnt - d0, ferr_cnt - f0);
    end
  endtask

  task automatic test_frame_err();
    int unsigned cycles, d0, f0;
    bit seen, busy_ok, restarted;
    Baud_set = 3'd4;
    d0 = done_cnt;
    f0 = ferr_cnt;
    fork
      send_frame(8'h3C, 1'b0, 16 * NB4, 0);
      wait_pulse(2 + 158 * NB4, cycles, seen, busy_ok);
    join
    n_vec++;
    if (!seen || ferr_cnt - f0 !== 1 || done_cnt - d0 !== 0) begin
      n_err++; $display("FAIL ferr_pulses: got ferr %0d done %0d, expected 1 0",
                        ferr_cnt - f0, done_cnt - d0);
    end
    n_vec++;
    if (Data_Byte !== 8'hFF) begin
      n_err++; $display("FAIL ferr_data: got %h, expected ff", Data_Byte);
    end
    // Line stays low (break); no new frame may begin.
    restarted = 1'b0;
    for (int i = 0; i < 48 * NB4; i++) begin
      @(negedge Clk);
      if (UART_state) restarted = 1'b1;
    end
    n_vec++;
    if (restarted !== 1'b0 || ferr_cnt - f0 !== 1) begin
      n_err++; $display("FAIL ferr_break: got restart %b ferr %0d, expected 0 1",
                        restarted, ferr_cnt - f0);
    end
    wait_clk(1);
    Rs232_Rx = 1'b1;
    wait_clk(20);
  endtask

  task automatic test_reset_abort();
    int unsigned cycles, d0, f0;
    bit seen, busy_ok;
    Baud_set = 3'd4;
    d0 = done_cnt;
    f0 = ferr_cnt;
    Rs232_Rx = 1'b0;
    wait_clk(16 * NB4);
    for (int i = 0; i < 4; i++) begin
      Rs232_Rx = (i % 2 == 0);
      wait_clk(16 * NB4);
    end
    Rs232_Rx = 1'b1;
    wait_clk(8 * NB4);
    n_vec++;
    if (UART_state !== 1'b1) begin
      n_err++; $display("FAIL abort_busy: got UART_state %b, expected 1", UART_state);
    end
    Rst = 1'b1;
    wait_clk(2);
    n_vec++;
    if (Data_Byte !== 8'h00 || UART_state !== 1'b0) begin
      n_err++; $display("FAIL abort_reset: got data %h state %b, expected 00 0",
                        Data_Byte, UART_state);
    end
    Rst = 1'b0;
    wait_clk(192 * NB4);
    n_vec++;
    if (done_cnt - d0 !== 0 || ferr_cnt - f0 !== 0 || UART_state !== 1'b0) begin
      n_err++; $display("FAIL abort_quiet: got done %0d ferr %0d state %b, expected 0 0 0",
                        done_cnt - d0, ferr_cnt - f0, UART_state);
    end
    fork
      send_frame(8'hC3, 1'b1, 16 * NB4, 0);
      wait_pulse(2 + 158 * NB4, cycles, seen, busy_ok);
    join
    wait_clk(5);
    n_vec++;
    if (Data_Byte !== 8'hC3 || done_cnt - d0 !== 1 || ferr_cnt - f0 !== 0) begin
      n_err++; $display("FAIL abort_resume: got data %h done %0d ferr %0d, expected c3 1 0",
                        Data_Byte, done_cnt - d0, ferr_cnt - f0);
    end
  endtask

  task automatic test_baud_latch();
    int unsigned cycles, lat;
    bit seen, busy_ok;
    Baud_set = 3'd4;
    lat = 2 + 154 * NB4;
    fork
      send_frame(8'h5A, 1'b1, 16 * NB4, 0);
      begin
        wait_clk(40);
        Baud_set = 3'd0;
      end
      wait_pulse(2 * lat, cycles, seen, busy_ok);
    join
    wait_clk(5);
    n_vec++;
    if (!seen || cycles < lat - NB4 || cycles > lat + NB4 || Data_Byte !== 8'h5A) begin
      n_err++; $display("FAIL baud_latch: got %0d cycles data %h (seen %b), expected %0d 5a",
                        cycles, Data_Byte, seen, lat);
    end
    Baud_set = 3'd4;
  endtask

  task automatic test_glitch();
    int unsigned cycles, lat, d0;
    bit seen, busy_ok;
    Baud_set = 3'd2;
    lat = 2 + 154 * NB2;
    d0 = done_cnt;
    fork
      send_frame(8'h96, 1'b1, 16 * NB2, 9 * NB2);
      wait_pulse(lat + 4 * NB2, cycles, seen, busy_ok);
    join
    wait_clk(5);
    n_vec++;
    if (Data_Byte !== 8'h96 || done_cnt - d0 !== 1) begin
      n_err++; $display("FAIL glitch_data: got %h done %0d, expected 96 1",
                        Data_Byte, done_cnt - d0);
    end
    n_vec++;
    if (!seen || cycles < lat - NB2 || cycles > lat + NB2) begin
      n_err++; $display("FAIL glitch_latency: got %0d (seen %b), expected %0d +/- %0d",
                        cycles, seen, lat, NB2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    wait_clk(50);
    test_back_to_back();
    wait_clk(50);
    test_false_start();
    wait_clk(50);
    test_frame_err();
    wait_clk(50);
    test_reset_abort();
    wait_clk(50);
    test_baud_latch();
    wait_clk(50);
    test_glitch();
    n_vec++;
    if (both_cnt !== 0) begin
      n_err++; $display("FAIL exclusive_pulses: got %0d overlaps, expected 0", both_cnt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #(20 * 150_000);
    $display("FAIL watchdog: simulation exceeded 150000 cycles");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx_byte.md
UART_RX_BYTE -- requirements
Module: uart_rx_byte

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning Clk frequency in Hz used to derive baud tick periods.
REQ-002 SHALL have port Clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port Rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port Rs232_Rx  input  1  asynchronous serial line; idles high.
REQ-005 SHALL have port Baud_set  input  3  rate select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200; codes 5-7 decode as 9600.
REQ-006 SHALL have port Data_Byte  output  8  last correctly framed byte, held until the next good frame.
REQ-007 SHALL have port Rx_Done  output  1  one-cycle pulse when Data_Byte updates.
REQ-008 SHALL have port Frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-009 SHALL have port UART_state  output  1  high from start detect until the frame ends (Rx_Done, Frame_err or false start).

Function
REQ-010 SHALL pass Rs232_Rx through a 2-flop synchronizer, then a third edge-history register.
REQ-011 SHALL generate a 16x oversample tick every N Clk cycles, N = round(CLK_FREQ/(16*baud)); at 50 MHz N = 326/163/81/54/27 for codes 0-4.
REQ-012 SHALL latch Baud_set at start detect; Baud_set changes mid-frame SHALL have no effect on the current frame.
REQ-013 SHALL implement states IDLE, START, DATA, STOP.
REQ-014 IDLE: on a synchronized falling edge (history=1, current=0), SHALL clear the tick divider and tick count, assert UART_state and enter START.
REQ-015 Each bit period SHALL be 16 ticks (0-15); the bit value SHALL be the majority of samples at ticks 7, 8 and 9, decided at tick 9.
REQ-016 START: a majority of 1 SHALL be a false start: return to IDLE and deassert UART_state, with no Rx_Done or Frame_err; a majority of 0 SHALL continue to DATA at the end of tick 15.
REQ-017 DATA: SHALL shift 8 bits LSB first into an internal shift register; after bit 7 completes, SHALL enter STOP.
REQ-018 STOP: at tick 9, majority 1 SHALL load Data_Byte from the shift register, pulse Rx_Done for exactly one cycle and enter IDLE in that same cycle.
REQ-019 STOP: at tick 9, majority 0 SHALL pulse Frame_err for one cycle, leave Data_Byte unchanged and enter IDLE.
REQ-020 Rx_Done and Frame_err SHALL never assert in the same cycle.
REQ-021 Returning to IDLE at stop-bit tick 9 SHALL allow back-to-back frames with no idle gap to be received.
REQ-022 A line held low after a Frame_err (break) SHALL NOT start a new frame until a new falling edge occurs.
REQ-023 Rx_Done latency SHALL be 2 sync cycles + (9*16+10)*N Clk cycles after the pin falling edge, with tolerance +/-1 tick.

Reset
REQ-024 Rst high at a clock edge SHALL force state IDLE, Data_Byte=8'h00, Rx_Done=0, Frame_err=0, UART_state=0, and clear the divider, tick count, bit count and shift register.
REQ-025 SHALL reset the synchronizer and history registers to 0, so a line held low through reset release is not taken as a start bit.
REQ-026 Reset asserted mid-frame SHALL abandon the frame without any pulse output; reception SHALL resume on the next falling edge after Rst deasserts.

Verification
REQ-027 Scenario: Baud_set=4, send 8'hA5 with 1 stop bit -> Data_Byte=8'hA5, one Rx_Done pulse about 4160 cycles after the edge, UART_state high for the whole frame.
REQ-028 Scenario: Baud_set=0, send 8'h00 then 8'hFF back to back -> two Rx_Done pulses about 52160 cycles apart, Data_Byte 8'h00 then 8'hFF.
REQ-029 Scenario: Baud_set=4, 200-cycle low glitch on an idle line -> false start; no Rx_Done or Frame_err; UART_state falls within 16*27 cycles.
REQ-030 Scenario: Baud_set=4, frame 8'h3C with stop bit low -> one Frame_err pulse, Data_Byte keeps its previous value, no Rx_Done.
REQ-031 Scenario: Rst pulsed during data bit 4 of 8'h55, then a clean frame 8'hC3 -> no pulse for the aborted frame; Data_Byte=8'hC3 with one Rx_Done.
REQ-032 Scenario: Baud_set=2, one-clock glitch at a sample tick in each bit of 8'h96 -> majority vote yields Data_Byte=8'h96.
